muldiv: RTL
===========

# muldiv

Iterative multiply/divide unit for the RV64M/RV32M extension. It sits in the execute stage beside the single-cycle ALU and receives the same operand and funct fields when `funct7 == 7'h01`. It computes one result at a time over a fixed number of cycles, using a valid/ready handshake on both request and response. The integer pipeline stalls on the handshake.

## Interface
- `Xlen`, default `core_pkg::Xlen` (64): datapath width; 32 or 64 only.
- `clk_i  in  1`: single clock, rising edge.
- `rst_i  in  1`: reset, synchronous, active-high.
- `flush_i  in  1`: kill the in-flight operation (pipeline redirect).
- `valid_i  in  1`: request valid.
- `ready_o  out  1`: unit can accept a request.
- `funct3_i  in  3`: M-extension op; encoding is `core_pkg::mdop_e`.
- `word_i  in  1`: OP-32 variant (MULW/DIVW/…); ignored when Xlen == 32.
- `a_i  in  Xlen`: rs1 operand.
- `b_i  in  Xlen`: rs2 operand.
- `valid_o  out  1`: result valid.
- `ready_i  in  1`: consumer accepts the result.
- `res_o  out  Xlen`: result; held stable while `valid_o && !ready_i`.

## Operation
- FSM states and transitions:
  - Idle → Busy on `valid_i && ready_o`.
  - Busy → Done after the last iteration.
  - Done → Idle on `ready_i`.
  - `ready_o` is 1 only in Idle.
  - `valid_o` is 1 only in Done.
- Capture at acceptance: funct3, word flag, operands.
  - Word ops: operands are `a_i[31:0]` and `b_i[31:0]`, sign- or zero-extended per op. Iteration count N = 32.
  - Otherwise N = Xlen.
- Multiply:
  - Convert each operand to magnitude using its signedness: MUL/MULH are signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned.
  - Radix-2 shift-add into a 2N-bit product, one bit per cycle.
  - In the final Busy cycle, negate the product if exactly one signed operand is negative.
  - Result: MUL takes the low N bits. MULH, MULHSU and MULHU take the high N bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases bypass Busy and go Idle → Done directly (result at T+1):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative ÷ −1): quotient = dividend, remainder = 0.
- Word results are sign-extended from bit 31 to Xlen.
- Results are computed at full precision; no truncation other than the selection above.
- `flush_i`: in any state, the next state is Idle with `valid_o` = 0 and the result discarded. If `flush_i` and `valid_i` are high in the same Idle cycle, the request is not accepted.
- Reset: state Idle; `valid_o` = 0; `ready_o` = 1 from the first cycle after reset; `res_o` = 0. Reset mid-operation abandons it.

## Timing
- Handshake accepted in cycle T.
- Busy occupies cycles T+1 … T+N.
- `valid_o` rises in cycle T+N+1: latency 65 for 64-bit ops, 33 for word ops or Xlen = 32.
- Back-to-back:
  - `ready_i` high in the first Done cycle → Idle next cycle.
  - The earliest next acceptance is one cycle after the result handshake.
  - There is no accept-while-Done overlap.
- `res_o` and `valid_o` are registered outputs. `ready_o` is decoded from the state register only, with no combinational input→output paths.
- Inputs other than `valid_i` and `flush_i` are ignored outside the accept cycle.

## Structure
- `core_pkg` additions:
  - `mdop_e` enum: Mul=0, Mulh=1, Mulhsu=2, Mulhu=3, Div=4, Divu=5, Rem=6, Remu=7.
  - `mdstate_e` enum: Idle, Busy, Done.
- Single module; FSM, iteration counter ($clog2(Xlen)+1 bits) and shared shift/accumulate datapath in one file. No sub-module: multiply and divide share one 2Xlen accumulator register and one Xlen adder/subtractor.
- The decode stage routes `funct7 == 7'h01` here instead of the ALU; the ALU is not modified.

## Test plan
- MUL, a=7, b=−3 (Xlen 64) → `res_o` = 0xFFFF_FFFF_FFFF_FFEB with `valid_o` exactly 65 cycles after accept.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE; MULHSU, a=−1, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIV, a=−7, b=2 → −3; REM on the same operands → −1; DIVU, a=100, b=7 → 14.
- DIV by 0 → all ones and REM by 0 → a, with `valid_o` at T+1. DIV 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000 and REM → 0.
- DIVW, a=0x0000_0001_8000_0000, b=1 → 0xFFFF_FFFF_8000_0000 at T+33.
- Hold `ready_i` low 5 cycles: `res_o` stable and `ready_o` = 0. Then pulse `flush_i` mid-Busy: Idle next cycle, no `valid_o`. Assert `rst_i` mid-Busy: `valid_o` = 0 and `ready_o` = 1 after reset.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core types for the multiply/divide unit
package core_pkg;
    localparam int Xlen = 64;
    typedef enum logic [2:0] {
        Mul    = 3'd0,
        Mulh   = 3'd1,
        Mulhsu = 3'd2,
        Mulhu  = 3'd3,
        Div    = 3'd4,
        Divu   = 3'd5,
        Rem    = 3'd6,
        Remu   = 3'd7
    } mdop_e;
    typedef enum logic [1:0] {Idle, Busy, Done} mdstate_e;
endpackage

// File: rtl/muldiv.sv
// muldiv: iterative RV64M/RV32M multiply/divide unit, one result bit per cycle
// Ports: clk_i/rst_i clock and sync reset; flush_i kills the in-flight op;
// valid_i/ready_o request handshake with funct3_i, word_i, a_i, b_i;
// valid_o/ready_i response handshake with registered res_o.
module muldiv #(
    parameter int Xlen = core_pkg::Xlen
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [Xlen-1:0] a_i,
    input  logic [Xlen-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [Xlen-1:0] res_o
);
    import core_pkg::*;
    localparam int Cw = $clog2(Xlen) + 1;
    localparam int Ws = Xlen - 32;
    // Word extension: sign- or zero-extend bit 31 upward when w is set.
    function automatic logic [Xlen-1:0] ext(input logic [Xlen-1:0] v, input logic w, input logic s);
        logic signed [32:0] t;
        t = {s & v[31], v[31:0]};
        return w ? Xlen'(t) : v;
    endfunction
    mdstate_e          state_q;
    mdop_e             op_q, op;
    logic              w_q, neg_q, rneg_q;
    logic [Xlen-1:0]   b_q, res_q, res_d;
    logic [2*Xlen-1:0] acc_q, acc_d;
    logic [Cw-1:0]     cnt_q;
    logic              w, sa, sb, a_neg, b_neg, dz, ovf, dv;
    logic [Xlen-1:0]   a_e, b_e, ma, mb, mn, spec_res, hi, lo, mres, dres, q, r;
    logic [Xlen:0]     lhs, rhs, sum;
    logic [2*Xlen-1:0] prod, prod_s;
    assign ready_o = state_q == Idle;
    assign valid_o = state_q == Done;
    assign res_o   = res_q;
    always_comb begin
        op       = mdop_e'(funct3_i);
        w        = (Xlen == 64) && word_i;
        sa       = op inside {Mul, Mulh, Mulhsu, Div, Rem};
        sb       = op inside {Mul, Mulh, Div, Rem};
        a_e      = ext(a_i, w, sa);
        b_e      = ext(b_i, w, sb);
        a_neg    = sa & a_e[Xlen-1];
        b_neg    = sb & b_e[Xlen-1];
        ma       = a_neg ? -a_e : a_e;
        mb       = b_neg ? -b_e : b_e;
        mn       = w ? ~Xlen'(32'h7fff_ffff) : {1'b1, {(Xlen-1){1'b0}}};
        dz       = funct3_i[2] && b_e == '0;
        ovf      = funct3_i[2] && sa && a_e == mn && b_e == '1;
        spec_res = ext(funct3_i[1] ? (dz ? a_e : '0) : (dz ? '1 : a_e), w, 1'b1);
    end
    // One shared X+1-bit adder: shift-add for multiply, trial subtract for divide.
    always_comb begin
        hi     = acc_q[2*Xlen-1:Xlen];
        lo     = acc_q[Xlen-1:0];
        dv     = op_q[2];
        lhs    = dv ? {hi, lo[Xlen-1]} : {1'b0, hi};
        rhs    = dv ? ~{1'b0, b_q} : (lo[0] ? {1'b0, b_q} : '0);
        sum    = lhs + rhs + {{Xlen{1'b0}}, dv};
        acc_d  = dv ? {sum[Xlen] ? lhs[Xlen-1:0] : sum[Xlen-1:0], lo[Xlen-2:0], ~sum[Xlen]}
                    : {sum, lo[Xlen-1:1]};
        // A 32-iteration word multiply leaves its product Ws bits above the bottom.
        prod   = w_q ? acc_d >> Ws : acc_d;
        prod_s = neg_q ? -prod : prod;
        mres   = op_q == Mul ? prod_s[Xlen-1:0] : (w_q ? prod_s[Xlen+31:32] : prod_s[2*Xlen-1:Xlen]);
        q      = acc_d[Xlen-1:0];
        r      = acc_d[2*Xlen-1:Xlen];
        dres   = op_q[1] ? (rneg_q ? -r : r) : (neg_q ? -q : q);
        res_d  = ext(dv ? dres : mres, w_q, 1'b1);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            res_q   <= '0;
        end else if (flush_i) begin
            state_q <= Idle;
        end else begin
            case (state_q)
                Idle: if (valid_i) begin
                    op_q    <= op;
                    w_q     <= w;
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    b_q     <= mb;
                    // Word dividends are left-aligned so 32 shifts consume them fully.
                    acc_q   <= {{Xlen{1'b0}}, (funct3_i[2] && w) ? ma << Ws : ma};
                    cnt_q   <= w ? Cw'(32) : Cw'(Xlen);
                    state_q <= (dz || ovf) ? Done : Busy;
                    if (dz || ovf) res_q <= spec_res;
                end
                Busy: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - Cw'(1);
                    if (cnt_q == Cw'(1)) begin
                        res_q   <= res_d;
                        state_q <= Done;
                    end
                end
                Done: if (ready_i) state_q <= Idle;
                default: state_q <= Idle;
            endcase
        end
    end
endmodule
